// File: rtl/decode_unit_if.sv
// RV32I decode-stage bundle: instruction word, one-hot format enables and decoded fields.
// Latency: n/a (signal bundle only).
// Backpressure: none; the decoder consumes a new instruction every cycle.
interface decode_unit_if;
    logic [31:0] instr_i;
    logic        I_EN_i;
    logic        R_EN_i;
    logic        S_EN_i;
    logic        SB_EN_i;
    logic        U_EN_i;
    logic        UJ_EN_i;
    logic [31:0] immed_o;
    logic [4:0]  RS1_o;
    logic [4:0]  RS2_o;
    logic [4:0]  RD_o;
    logic [6:0]  opcode_o;
    logic [2:0]  func3_o;
    logic [6:0]  func7_o;

    // Control/fetch side: supplies the instruction and format enables, observes decoded fields.
    modport master (
        output instr_i, I_EN_i, R_EN_i, S_EN_i, SB_EN_i, U_EN_i, UJ_EN_i,
        input  immed_o, RS1_o, RS2_o, RD_o, opcode_o, func3_o, func7_o
    );

    // Decoder side.
    modport slave (
        input  instr_i, I_EN_i, R_EN_i, S_EN_i, SB_EN_i, U_EN_i, UJ_EN_i,
        output immed_o, RS1_o, RS2_o, RD_o, opcode_o, func3_o, func7_o
    );
endinterface

// File: rtl/decode_unit.sv
// RV32I field decoder: extracts register indices, opcode, func3/func7 and sign-extended immediate.
// Latency: 1 cycle; fields for the instruction sampled at edge N are visible after edge N.
// Backpressure: none; a new instruction is accepted on every clock edge.
module decode_unit (
    input  logic          clk_i,
    input  logic          rst_ni,
    decode_unit_if.slave  bus
);

    logic [31:0] instr;

    // Immediate candidates for each format; sign bit is always instr[31].
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_sb;
    logic [31:0] imm_u;
    logic [31:0] imm_uj;

    // Next-state values for the output registers.
    logic [31:0] immed_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;
    logic [6:0]  opcode_d;
    logic [2:0]  func3_d;
    logic [6:0]  func7_d;

    // Output registers.
    logic [31:0] immed_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [6:0]  opcode_q;
    logic [2:0]  func3_q;
    logic [6:0]  func7_q;

    logic        is_shift_imm;

    assign instr = bus.instr_i;

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_sb = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_uj = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Only slli/srli/srai carry a meaningful func7 inside an I-type word.
    assign is_shift_imm = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

    // Select fields by the highest-priority enable (R > I > S > SB > U > UJ); undefined fields stay 0.
    always_comb begin
        immed_d  = 32'd0;
        rs1_d    = 5'd0;
        rs2_d    = 5'd0;
        rd_d     = 5'd0;
        opcode_d = instr[6:0];
        func3_d  = 3'd0;
        func7_d  = 7'd0;

        if (bus.R_EN_i) begin
            rd_d    = instr[11:7];
            func3_d = instr[14:12];
            rs1_d   = instr[19:15];
            rs2_d   = instr[24:20];
            func7_d = instr[31:25];
        end else if (bus.I_EN_i) begin
            rd_d    = instr[11:7];
            func3_d = instr[14:12];
            rs1_d   = instr[19:15];
            immed_d = imm_i;
            if (is_shift_imm) begin
                func7_d = instr[31:25];
            end
        end else if (bus.S_EN_i) begin
            func3_d = instr[14:12];
            rs1_d   = instr[19:15];
            rs2_d   = instr[24:20];
            immed_d = imm_s;
        end else if (bus.SB_EN_i) begin
            func3_d = instr[14:12];
            rs1_d   = instr[19:15];
            rs2_d   = instr[24:20];
            immed_d = imm_sb;
        end else if (bus.U_EN_i) begin
            rd_d    = instr[11:7];
            immed_d = imm_u;
        end else if (bus.UJ_EN_i) begin
            rd_d    = instr[11:7];
            immed_d = imm_uj;
        end
    end

    // Register decoded fields; synchronous reset wins over any decode in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            immed_q  <= 32'd0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 5'd0;
            opcode_q <= 7'd0;
            func3_q  <= 3'd0;
            func7_q  <= 7'd0;
        end else begin
            immed_q  <= immed_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            opcode_q <= opcode_d;
            func3_q  <= func3_d;
            func7_q  <= func7_d;
        end
    end

    assign bus.immed_o  = immed_q;
    assign bus.RS1_o    = rs1_q;
    assign bus.RS2_o    = rs2_q;
    assign bus.RD_o     = rd_q;
    assign bus.opcode_o = opcode_q;
    assign bus.func3_o  = func3_q;
    assign bus.func7_o  = func7_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: hand-computed RV32I decodes checked with immediate assertions.
// Latency: checks sampled 1 time unit after the edge that registers each instruction.
// Backpressure: none exercised; the decoder accepts every cycle.
module tb_decode_unit;

    logic clk_i;
    logic rst_ni;
    int   total;
    int   bad;

    decode_unit_if bus ();

    decode_unit dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    // 10-unit clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] op,
                             input logic [31:0] imm);
        check({tag, ".rd"},     {27'd0, bus.RD_o},     {27'd0, rd});
        check({tag, ".rs1"},    {27'd0, bus.RS1_o},    {27'd0, rs1});
        check({tag, ".rs2"},    {27'd0, bus.RS2_o},    {27'd0, rs2});
        check({tag, ".func3"},  {29'd0, bus.func3_o},  {29'd0, f3});
        check({tag, ".func7"},  {25'd0, bus.func7_o},  {25'd0, f7});
        check({tag, ".opcode"}, {25'd0, bus.opcode_o}, {25'd0, op});
        check({tag, ".immed"},  bus.immed_o,           imm);
    endtask

    // Apply instruction/enables {R,I,S,SB,U,UJ}, then clock them in and settle past the edge.
    task automatic step(input logic [31:0] ins, input logic [5:0] en);
        bus.instr_i = ins;
        bus.R_EN_i  = en[5];
        bus.I_EN_i  = en[4];
        bus.S_EN_i  = en[3];
        bus.SB_EN_i = en[2];
        bus.U_EN_i  = en[1];
        bus.UJ_EN_i = en[0];
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [5:0] EN_R  = 6'b100000;
    localparam logic [5:0] EN_I  = 6'b010000;
    localparam logic [5:0] EN_S  = 6'b001000;
    localparam logic [5:0] EN_SB = 6'b000100;
    localparam logic [5:0] EN_U  = 6'b000010;
    localparam logic [5:0] EN_UJ = 6'b000001;

    initial begin
        total = 0;
        bad   = 0;
        rst_ni = 1'b0;
        bus.instr_i = 32'd0;
        bus.R_EN_i = 1'b0; bus.I_EN_i = 1'b0; bus.S_EN_i = 1'b0;
        bus.SB_EN_i = 1'b0; bus.U_EN_i = 1'b0; bus.UJ_EN_i = 1'b0;

        // Reset held for two edges with an all-ones R-type word presented.
        step(32'hFFFF_FFFF, EN_R);
        check_all("rst1", 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'd0, 32'd0);
        step(32'hFFFF_FFFF, EN_R);
        check_all("rst2", 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'd0, 32'd0);

        // First edge after release decodes the same word as R-type.
        rst_ni = 1'b1;
        step(32'hFFFF_FFFF, EN_R);
        check_all("post_rst", 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 7'h7F, 32'd0);

        // add x3,x1,x2
        step(32'h0020_81B3, EN_R);
        check_all("add", 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 7'h33, 32'd0);
        // Outputs hold until the next edge even when the input changes.
        bus.instr_i = 32'h1234_5678;
        bus.R_EN_i  = 1'b0;
        bus.U_EN_i  = 1'b1;
        #3;
        check("hold.rd", {27'd0, bus.RD_o}, 32'd3);
        check("hold.opcode", {25'd0, bus.opcode_o}, 32'h33);

        // addi x5,x6,-1: non-shift I-type keeps func7 at 0.
        step(32'hFFF3_0293, EN_I);
        check_all("addi", 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 7'h13, 32'hFFFF_FFFF);

        // srai x1,x1,3: shift-immediate exposes func7.
        step(32'h4030_D093, EN_I);
        check_all("srai", 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 7'h13, 32'h0000_0403);

        // slli x2,x3,4 (func3=001).
        step(32'h0041_9113, EN_I);
        check_all("slli", 5'd2, 5'd3, 5'd0, 3'd1, 7'd0, 7'h13, 32'h0000_0004);

        // sw x2,8(x1)
        step(32'h0020_A423, EN_S);
        check_all("sw", 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 7'h23, 32'h0000_0008);

        // beq x1,x2,-4
        step(32'hFE20_8EE3, EN_SB);
        check_all("beq", 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 7'h63, 32'hFFFF_FFFC);

        // lui x7,0x12345
        step(32'h1234_53B7, EN_U);
        check_all("lui", 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37, 32'h1234_5000);

        // jal x1,2048
        step(32'h0010_00EF, EN_UJ);
        check_all("jal", 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7'h6F, 32'h0000_0800);

        // R and I together: R wins.
        step(32'h0020_81B3, EN_R | EN_I);
        check_all("prio_ri", 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 7'h33, 32'd0);

        // S and U together on sw word: S wins.
        step(32'h0020_A423, EN_S | EN_U);
        check_all("prio_su", 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 7'h23, 32'h0000_0008);

        // U and UJ together on lui word: U wins.
        step(32'h1234_53B7, EN_U | EN_UJ);
        check_all("prio_uuj", 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 7'h37, 32'h1234_5000);

        // No enable: only opcode follows the instruction.
        step(32'h0020_81B3, 6'b000000);
        check_all("none", 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'h33, 32'd0);

        // Reset overrides a decode in the same cycle.
        rst_ni = 1'b0;
        step(32'hFE20_8EE3, EN_SB);
        check_all("rst_late", 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 7'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_unit.md
Name: decode_unit

Overview:
RV32I instruction field decoder in the core's decode stage. It takes a 32-bit instruction plus one-hot instruction-format enables from the control unit. It registers the extracted fields: rs1, rs2, rd, opcode, func3, func7, and the sign-extended, format-specific immediate. Outputs feed the register file, ALU control and the immediate mux.

Parameters:
None (XLEN fixed at 32).

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  synchronous active-low reset
- instr_i  input  32  instruction word
- I_EN_i  input  1  I-type format select
- R_EN_i  input  1  R-type format select
- S_EN_i  input  1  S-type format select
- SB_EN_i  input  1  SB (branch) format select
- U_EN_i  input  1  U-type format select
- UJ_EN_i  input  1  UJ (jal) format select
- immed_o  output  32  sign-extended immediate
- RS1_o  output  5  source register 1 index
- RS2_o  output  5  source register 2 index
- RD_o  output  5  destination register index
- opcode_o  output  7  instr[6:0]
- func3_o  output  3  instr[14:12] where defined
- func7_o  output  7  instr[31:25] where defined

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- All outputs are registered. Latency is 1 cycle: fields for the instr_i/enables sampled at edge N appear after edge N and are held until the next edge.
- Reset: on a rising edge with rst_ni=0, every output is cleared to 0. Inputs are ignored. Reset overrides any decode in the same cycle.
- opcode_o = instr[6:0] for every format, including when no enable is set.
- Enable priority when more than one enable is high: R > I > S > SB > U > UJ. The highest-priority asserted enable selects the format.
- Fields not defined by the selected format are driven to 0.
- R: RD=[11:7], func3=[14:12], RS1=[19:15], RS2=[24:20], func7=[31:25], immed=0.
- I: RD=[11:7], func3=[14:12], RS1=[19:15], RS2=0.
  - immed = sext(instr[31:20]).
  - func7 = instr[31:25] only when func3 is 001 or 101 (shift-immediate); otherwise func7=0.
- S: RS1, RS2, func3 as for R-type; RD=0, func7=0.
  - immed = sext({instr[31:25], instr[11:7]}).
- SB: RS1, RS2, func3 as for R-type; RD=0, func7=0.
  - immed = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U: RD=[11:7]; RS1=RS2=func3=func7=0.
  - immed = {instr[31:12], 12'b0}.
- UJ: RD=[11:7]; RS1=RS2=func3=func7=0.
  - immed = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- No enable asserted: opcode_o updated, all other outputs 0.
- Sign extension always replicates instr[31].
- No checks for illegal opcodes; decode is purely enable-driven.

Test Plan:
- Reset: hold rst_ni=0 for 2 edges with instr_i=0xFFFFFFFF and R_EN_i=1 -> all outputs 0. Release rst_ni; one edge later, fields decode normally.
- R_EN, instr 0x002081B3 (add x3,x1,x2) -> RD=3, RS1=1, RS2=2, func3=0, func7=0, opcode=0x33, immed=0, valid one cycle after the sampling edge.
- I_EN, instr 0xFFF30293 (addi x5,x6,-1) -> RD=5, RS1=6, RS2=0, immed=0xFFFFFFFF, opcode=0x13, func7=0.
- I_EN, instr 0x4030D093 (srai x1,x1,3) -> func3=5, func7=0x20, immed=0x00000403.
- S_EN, instr 0x0020A423 (sw x2,8(x1)) -> RS1=1, RS2=2, func3=2, RD=0, immed=0x00000008.
  - Then SB_EN, instr 0xFE208EE3 (beq x1,x2,-4) -> RS1=1, RS2=2, immed=0xFFFFFFFC.
- U_EN, instr 0x123453B7 (lui x7,0x12345) -> RD=7, immed=0x12345000.
  - Then UJ_EN, instr 0x001000EF (jal x1,2048) -> RD=1, immed=0x00000800.
  - Then R_EN+I_EN together with 0x002081B3 -> R-type decode (priority).
  - Then no enable -> opcode=0x33, all else 0.
